if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/if_id_reg.sv | 65 ++++++
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch path.
// Holds the datapath width, the default bubble encoding, the PC step and the
// fetch FSM state encoding, so that every pipeline stage agrees on them.
package pipeline_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- the canonical RISC-V no-op used as a pipeline bubble
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Sequential fetch stride; the adder wraps naturally modulo 2^XLEN
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch.
// Ports:
//   clk_i     - clock, rising edge
//   rst_ni    - asynchronous active-low reset
//   load_i    - capture pc_i/instr_i as a valid instruction
//   bubble_i  - replace the held instruction with a bubble (wins over load_i)
//   pc_i      - PC of the instruction being captured
//   instr_i   - instruction word being captured
//   pc_o      - latched PC (left untouched when a bubble is loaded)
//   instr_o   - latched instruction word
//   valid_o   - latched instruction is real, not a bubble
// With neither load_i nor bubble_i asserted the latch holds its contents.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  // A bubble keeps the old PC on purpose: it is don't-care while invalid,
  // and not touching it saves a mux input on the PC field.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bubble_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection, boot FSM,
// squash counter and the IF/ID latch.
// Ports:
//   clk           - clock, rising edge
//   rst_n         - asynchronous active-low reset
//   flush         - squash/redirect request, highest priority
//   branch_target - redirect address, word-aligned on use
//   stall         - freeze PC and IF/ID
//   imem_addr     - instruction memory address (the PC, combinational)
//   imem_rdata    - instruction word for imem_addr
//   imem_valid    - imem_rdata is usable this cycle
//   if_id_pc      - PC of the latched instruction
//   if_id_instr   - latched instruction
//   if_id_valid   - latched instruction is real
//   flush_count   - saturating count of squashed valid instructions
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid,
  output logic [15:0]     flush_count
);

  localparam logic [15:0] FLUSH_CNT_MAX = 16'hFFFF;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [15:0]     flush_count_q, flush_count_d;
  logic            id_load, id_bubble;
  logic            unused_bt_lsb;

  // Redirects are always word-aligned, so the two low target bits never matter
  assign unused_bt_lsb = ^branch_target[1:0];

  // Flush beats everything, including BOOT; after that the cycle is either
  // the single BOOT bubble or the RUN priority chain stall > miss > advance.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_count_d = flush_count_q;
    id_load       = 1'b0;
    id_bubble     = 1'b0;
    if (flush) begin
      state_d   = RUN;
      pc_d      = {branch_target[XLEN-1:2], 2'b00};
      id_bubble = 1'b1;
      if (if_id_valid && (flush_count_q != FLUSH_CNT_MAX)) begin
        flush_count_d = flush_count_q + 16'd1;
      end
    end else begin
      case (state_q)
        BOOT: begin
          state_d   = RUN;
          pc_d      = RESET_PC;
          id_bubble = 1'b1;
        end
        RUN: begin
          if (stall) begin
            id_load = 1'b0;
          end else if (!imem_valid) begin
            id_bubble = 1'b1;
          end else begin
            id_load = 1'b1;
            pc_d    = pc_q + PC_STEP;
          end
        end
        default: begin
          state_d   = BOOT;
          id_bubble = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_count_q <= flush_count_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (id_load),
    .bubble_i(id_bubble),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr),
    .valid_o (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_if_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic        stall = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [15:0] flush_count;

  int testsRun = 0;
  int failCount = 0;

  // Behavioural model state
  logic        mBoot;
  logic [31:0] mPc;
  logic [31:0] mIfPc;
  logic [31:0] mIfInstr;
  logic        mIfValid;
  logic [15:0] mCount;

  if_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .branch_target(branch_target),
    .stall        (stall),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0] ^ 16'h5A5A, addr[31:16] ^ 16'h0C3F};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mBoot    = 1'b1;
    mPc      = RESET_PC;
    mIfPc    = '0;
    mIfInstr = NOP;
    mIfValid = 1'b0;
    mCount   = '0;
  endtask

  // One clock of the fetch rules, written directly from the behaviour list
  task automatic modelStep(input logic f, input logic [31:0] bt, input logic s,
                           input logic v, input logic [31:0] rdata);
    if (f) begin
      if (mIfValid && mCount != 16'hFFFF) mCount = mCount + 16'd1;
      mPc      = bt & 32'hFFFF_FFFC;
      mIfInstr = NOP;
      mIfValid = 1'b0;
      mBoot    = 1'b0;
    end else if (mBoot) begin
      mBoot    = 1'b0;
      mPc      = RESET_PC;
      mIfInstr = NOP;
      mIfValid = 1'b0;
    end else if (s) begin
      mPc = mPc;
    end else if (!v) begin
      mIfInstr = NOP;
      mIfValid = 1'b0;
    end else begin
      mIfPc    = mPc;
      mIfInstr = rdata;
      mIfValid = 1'b1;
      mPc      = mPc + 32'd4;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_addr"}, imem_addr, mPc);
    checkOutput({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, mIfValid});
    checkOutput({tag, "_instr"}, if_id_instr, mIfInstr);
    checkOutput({tag, "_count"}, {16'b0, flush_count}, {16'b0, mCount});
    if (mIfValid) checkOutput({tag, "_pc"}, if_id_pc, mIfPc);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_addr"}, imem_addr, RESET_PC);
    checkOutput({tag, "_pc"}, if_id_pc, 32'h0);
    checkOutput({tag, "_instr"}, if_id_instr, NOP);
    checkOutput({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
    checkOutput({tag, "_count"}, {16'b0, flush_count}, 32'h0);
  endtask

  // Called 1 time unit after a rising edge; drives inputs, advances one clock,
  // steps the model and checks 1 time unit after the edge.
  task automatic applyStimulus(input string tag, input logic f, input logic [31:0] bt,
                               input logic s, input logic v);
    logic [31:0] rdata;
    rdata         = v ? memWord(mPc) : 32'hDEAD_BEEF;
    flush         = f;
    branch_target = bt;
    stall         = s;
    imem_valid    = v;
    imem_rdata    = rdata;
    @(posedge clk);
    modelStep(f, bt, s, v, rdata);
    #1;
    checkAll(tag);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    // Boot bubble, then 0x0, 0x4, 0x8, 0xC fetched back to back
    applyStimulus("boot", 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("boot_bubble", {31'b0, if_id_valid}, 32'h0);
    applyStimulus("seq0", 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("seq0_ifpc", if_id_pc, 32'h0);
    applyStimulus("seq1", 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("seq1_ifpc", if_id_pc, 32'h4);
    applyStimulus("seq2", 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("seq2_ifpc", if_id_pc, 32'h8);
    applyStimulus("seq3", 1'b0, 32'h0, 1'b0, 1'b1);

    // Three stalled cycles at PC 0x10 with 0xC held in IF/ID
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("stall_addr", imem_addr, 32'h10);
      checkOutput("stall_ifpc", if_id_pc, 32'hC);
    end
    applyStimulus("resume", 1'b0, 32'h0, 1'b0, 1'b1);

    // Squash a valid instruction with an unaligned target
    applyStimulus("flush", 1'b1, 32'h103, 1'b0, 1'b1);
    checkOutput("flush_addr", imem_addr, 32'h100);
    checkOutput("flush_cnt", {16'b0, flush_count}, 32'h1);
    applyStimulus("postflush", 1'b0, 32'h0, 1'b0, 1'b1);

    // Flush with stall: redirect wins; second one squashes only a bubble
    applyStimulus("flushstall_v", 1'b1, 32'h200, 1'b1, 1'b1);
    applyStimulus("flushstall_b", 1'b1, 32'h300, 1'b1, 1'b1);
    checkOutput("flushstall_cnt", {16'b0, flush_count}, 32'h2);

    // PC wrap from the top of the address space
    applyStimulus("towrap", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    applyStimulus("wrap", 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    applyStimulus("afterwrap", 1'b0, 32'h0, 1'b0, 1'b1);

    // Instruction memory misses
    applyStimulus("miss0", 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("miss1", 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("hit", 1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 9) == 0),
                    $urandom(),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 4) != 0));
    end

    // Counter saturation: preload near the top, then squash twice
    force dut.flush_count_q = 16'hFFFE;
    #1;
    release dut.flush_count_q;
    mCount = 16'hFFFE;
    applyStimulus("sat_fill", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus("sat_flush0", 1'b1, 32'h40, 1'b0, 1'b1);
    checkOutput("sat_top", {16'b0, flush_count}, 32'hFFFF);
    applyStimulus("sat_fill2", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus("sat_flush1", 1'b1, 32'h80, 1'b0, 1'b1);
    checkOutput("sat_hold", {16'b0, flush_count}, 32'hFFFF);

    // Reset asserted between edges must act immediately
    applyStimulus("premid", 1'b0, 32'h0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midreset");
    rst_n = 1'b1;
    modelReset();
    applyStimulus("reboot", 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("rerun", 1'b0, 32'h0, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
